// File: rtl/tx_8b10b_sched.sv
// -----------------------------------------------------------------------------
// tx_8b10b_sched
//
// Symbol scheduler and running-disparity controller that sits in front of a
// combinational 8b/10b encoder on the serial transmit path.
//
//   * User bytes (with a data/control flag) are buffered in a small FIFO.
//   * After i_en rises the link is aligned with ALIGN_LEN K28.5 commas.
//   * In RUN, user bytes are sent when available, gaps are filled with idle
//     K28.5, and a comma is forced after IDLE_PERIOD consecutive non-commas.
//   * One symbol per clock is presented to the encoder with the current RD;
//     the returned codeword is registered, RD is updated from its ones count
//     and illegal disparity is flagged (sticky).
//
// Ports
//   i_clk          symbol clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_en           link enable
//   i_data/i_k     user byte and control flag, written when i_valid & o_ready
//   i_valid        user byte valid
//   o_ready        FIFO can accept a byte (never in IDLE)
//   o_enc_data     byte to encoder
//   o_enc_k        control flag to encoder
//   o_enc_rd       running disparity to encoder (0 = RD-, 1 = RD+)
//   i_enc_code     10b codeword returned combinationally by the encoder
//   o_code         registered codeword to serializer
//   o_code_valid   o_code holds a valid symbol
//   o_state        0 = IDLE, 1 = ALIGN, 2 = RUN
//   o_err_disp     sticky disparity error
// -----------------------------------------------------------------------------
module tx_8b10b_sched #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALIGN_LEN   = 16,
  parameter int IDLE_PERIOD = 256
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [7:0] i_data,
  input  logic       i_k,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_enc_data,
  output logic       o_enc_k,
  output logic       o_enc_rd,
  input  logic [9:0] i_enc_code,
  output logic [9:0] o_code,
  output logic       o_code_valid,
  output logic [1:0] o_state,
  output logic       o_err_disp
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int ACW = $clog2(ALIGN_LEN + 1);
  localparam int NCW = $clog2(IDLE_PERIOD + 1);

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // User FIFO: entries are {k, data}
  // ---------------------------------------------------------------------------
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop, flush;
  logic [8:0]    head;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign o_ready = !full && (state != ST_IDLE);
  assign push    = i_valid && o_ready;
  assign head    = mem[rd_ptr];

  // NOTE: storage carries no reset; the pointers and count define which
  // entries are live, so clearing them is enough to empty the FIFO.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_k, i_data};
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: state, alignment counter and non-comma counter
  // ---------------------------------------------------------------------------
  logic [ACW-1:0] align_cnt, align_next;
  logic [NCW-1:0] nc_cnt, nc_next;
  logic           sel;
  logic [7:0]     sel_data;
  logic           sel_k;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      align_cnt <= '0;
      nc_cnt    <= '0;
    end else begin
      state     <= state_next;
      align_cnt <= align_next;
      nc_cnt    <= nc_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    align_next = align_cnt;
    nc_next    = nc_cnt;
    sel        = 1'b0;
    sel_data   = K28_5;
    sel_k      = 1'b1;
    pop        = 1'b0;
    flush      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_en) begin
          state_next = ST_ALIGN;
          align_next = '0;
        end
      end

      ST_ALIGN: begin
        if (!i_en) begin
          state_next = ST_IDLE;
          flush      = 1'b1;
        end else begin
          // Comma every cycle; the FIFO may fill but is not drained here.
          sel     = 1'b1;
          nc_next = '0;
          if (align_cnt == ACW'(ALIGN_LEN - 1)) begin
            state_next = ST_RUN;
            align_next = '0;
          end else begin
            align_next = align_cnt + 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (!i_en) begin
          state_next = ST_IDLE;
          flush      = 1'b1;
        end else begin
          sel = 1'b1;
          if (nc_cnt == NCW'(IDLE_PERIOD)) begin
            // Forced comma keeps the receiver's word alignment refreshed.
            nc_next = '0;
          end else if (!empty) begin
            pop      = 1'b1;
            sel_data = head[7:0];
            sel_k    = head[8];
            // A user K28.5 also counts as a comma.
            if (head[8] && (head[7:0] == K28_5)) nc_next = '0;
            else                                 nc_next = nc_cnt + 1'b1;
          end else begin
            nc_next = '0;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        flush      = 1'b1;
      end
    endcase
  end

  assign o_state = state;

  // ---------------------------------------------------------------------------
  // Pipeline: selection -> encoder inputs (edge N), codeword capture (edge N+1)
  // ---------------------------------------------------------------------------
  logic sel_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_enc_data <= K28_5;
      o_enc_k    <= 1'b1;
      sel_valid  <= 1'b0;
    end else begin
      sel_valid <= sel;
      if (sel) begin
        o_enc_data <= sel_data;
        o_enc_k    <= sel_k;
      end
    end
  end

  // Ones count of the returned codeword drives the RD decision.
  logic [3:0] ones;
  logic       rd_next;
  logic       disp_bad;

  always_comb begin
    ones = '0;
    for (int b = 0; b < 10; b++) begin
      ones = ones + 4'(i_enc_code[b]);
    end
  end

  always_comb begin
    rd_next  = o_enc_rd;
    disp_bad = 1'b0;
    case (ones)
      4'd5: rd_next = o_enc_rd;
      4'd6: begin
        if (!o_enc_rd) rd_next  = 1'b1;
        else           disp_bad = 1'b1;
      end
      4'd4: begin
        if (o_enc_rd) rd_next  = 1'b0;
        else          disp_bad = 1'b1;
      end
      default: disp_bad = 1'b1;
    endcase
  end

  // RD survives IDLE; only reset returns it to RD-.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_code       <= '0;
      o_code_valid <= 1'b0;
      o_enc_rd     <= 1'b0;
      o_err_disp   <= 1'b0;
    end else begin
      o_code_valid <= sel_valid;
      if (sel_valid) begin
        o_code <= i_enc_code;
        if (disp_bad) o_err_disp <= 1'b1;
        else          o_enc_rd   <= rd_next;
      end
    end
  end

endmodule
